// File: rtl/branch_resolve_unit.sv
// Branch resolution for the execute stage: evaluates the RV32 branch set,
// trains a direct-mapped 2-bit bimodal predictor and issues a registered redirect pulse.
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_f,
    output logic             pred_taken_f,
    input  logic             ex_valid,
    input  logic [3:0]       br_op,
    input  logic [XLEN-1:0]  operand1,
    input  logic [XLEN-1:0]  operand2,
    input  logic [XLEN-1:0]  pc_x,
    input  logic [XLEN-1:0]  target_x,
    input  logic             pred_taken_x,
    output logic             br_taken,
    output logic             redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic [3:0] {
        OP_NB   = 4'd0,
        OP_BEQ  = 4'd1,
        OP_BNE  = 4'd2,
        OP_BLT  = 4'd3,
        OP_UC   = 4'd4,
        OP_BGE  = 4'd5,
        OP_BLTU = 4'd6,
        OP_BGEU = 4'd7
    } br_op_e;

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_x;
    logic             taken;
    logic             is_cond;
    logic             eff_v;
    logic             cond;
    logic             mp;
    logic [1:0]       bht_cur;
    logic [1:0]       bht_next;
    logic [XLEN-1:0]  next_pc;
    logic             unused_pc_bits;

    // Word-aligned PC bits select the entry; everything else aliases.
    assign idx_f = pc_f[IDX_W+1:2];
    assign idx_x = pc_x[IDX_W+1:2];
    assign unused_pc_bits = ^{pc_f[XLEN-1:IDX_W+2], pc_f[1:0]};

    assign pred_taken_f = bht[idx_f][1];

    always_comb begin
        // NOTE: default first so every path assigns taken and no latch is inferred.
        taken   = 1'b0;
        is_cond = 1'b0;
        case (br_op)
            OP_BEQ:  begin taken = (operand1 == operand2);                   is_cond = 1'b1; end
            OP_BNE:  begin taken = (operand1 != operand2);                   is_cond = 1'b1; end
            OP_BLT:  begin taken = ($signed(operand1) <  $signed(operand2)); is_cond = 1'b1; end
            OP_BGE:  begin taken = ($signed(operand1) >= $signed(operand2)); is_cond = 1'b1; end
            OP_BLTU: begin taken = (operand1 <  operand2);                   is_cond = 1'b1; end
            OP_BGEU: begin taken = (operand1 >= operand2);                   is_cond = 1'b1; end
            OP_UC:   taken = 1'b1;
            default: ;
        endcase
    end

    // The instruction behind a redirect is wrong-path and must leave no trace.
    assign eff_v = ex_valid & ~redirect;
    assign cond  = eff_v & is_cond;
    assign mp    = (cond & (taken != pred_taken_x))
                 | (eff_v & (br_op == OP_UC) & ~pred_taken_x);

    assign next_pc = taken ? target_x : pc_x + XLEN'(4);

    always_comb begin
        bht_cur  = bht[idx_x];
        bht_next = bht_cur;
        if (taken) begin
            if (bht_cur != 2'b11) bht_next = bht_cur + 2'd1;
        end else begin
            if (bht_cur != 2'b00) bht_next = bht_cur - 2'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_taken         <= 1'b0;
            redirect         <= 1'b0;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
            // NOTE: the BHT is flops, not SRAM, so it can and must be reset to weakly not-taken.
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
        end else begin
            br_taken         <= eff_v & taken;
            redirect         <= mp;
            if (mp) redirect_pc <= next_pc;
            branch_count     <= branch_count + CNT_W'(cond);
            mispredict_count <= mispredict_count + CNT_W'(mp);
            if (cond) bht[idx_x] <= bht_next;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: outcome, predictor training, squash,
// wrap and reset behaviour, with hand-computed expectations.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic        ex_valid;
    logic [3:0]  br_op;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [31:0] pc_x;
    logic [31:0] target_x;
    logic        pred_taken_x;
    logic        br_taken;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int total = 0;
    int bad   = 0;
    int exp_bc = 0;
    int exp_mc = 0;

    localparam logic [3:0] NB = 4'd0, BEQ = 4'd1, BNE = 4'd2, BLT = 4'd3, UC = 4'd4,
                           BGE = 4'd5, BLTU = 4'd6, BGEU = 4'd7;

    branch_resolve_unit dut (
        .clk              (clk),
        .rst              (rst),
        .pc_f             (pc_f),
        .pred_taken_f     (pred_taken_f),
        .ex_valid         (ex_valid),
        .br_op            (br_op),
        .operand1         (operand1),
        .operand2         (operand2),
        .pc_x             (pc_x),
        .target_x         (target_x),
        .pred_taken_x     (pred_taken_x),
        .br_taken         (br_taken),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pcx, input logic [31:0] tgt, input logic pred);
        ex_valid     = 1'b1;
        br_op        = op;
        operand1     = a;
        operand2     = b;
        pc_x         = pcx;
        target_x     = tgt;
        pred_taken_x = pred;
    endtask

    task automatic idle;
        ex_valid = 1'b0;
        br_op    = NB;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ex_valid = 1'b0; br_op = NB; operand1 = '0; operand2 = '0;
        pc_x = '0; target_x = '0; pred_taken_x = 1'b0; pc_f = 32'h40;
        tick(); tick();
        rst = 1'b0;
        #1;
        total++; if (br_taken !== 1'b0) begin bad++; $display("FAIL reset_br_taken got=%0b want=0", br_taken); end
        total++; if (redirect !== 1'b0) begin bad++; $display("FAIL reset_redirect got=%0b want=0", redirect); end
        total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_redirect_pc got=%h want=0", redirect_pc); end
        total++; if (branch_count !== 32'd0) begin bad++; $display("FAIL reset_branch_count got=%0d want=0", branch_count); end
        total++; if (mispredict_count !== 32'd0) begin bad++; $display("FAIL reset_mispredict_count got=%0d want=0", mispredict_count); end
        total++; if (pred_taken_f !== 1'b0) begin bad++; $display("FAIL reset_pred_0x40 got=%0b want=0", pred_taken_f); end
        for (int i = 0; i < 16; i++) begin
            pc_f = 32'(i) << 2;
            #1;
            total++;
            if (pred_taken_f !== 1'b0 || dut.bht[i] !== 2'b01) begin
                bad++;
                $display("FAIL reset_bht idx=%0d pred=%0b bht=%b want pred=0 bht=01", i, pred_taken_f, dut.bht[i]);
            end
        end
    endtask

    task automatic test_beq;
        drive(BEQ, 32'h5, 32'h5, 32'h100, 32'h180, 1'b0);
        tick();
        exp_bc++; exp_mc++;
        total++; if (br_taken !== 1'b1) begin bad++; $display("FAIL beq_br_taken got=%0b want=1", br_taken); end
        total++; if (redirect !== 1'b1) begin bad++; $display("FAIL beq_redirect got=%0b want=1", redirect); end
        total++; if (redirect_pc !== 32'h180) begin bad++; $display("FAIL beq_redirect_pc got=%h want=00000180", redirect_pc); end
        total++; if (mispredict_count !== 32'(exp_mc)) begin bad++; $display("FAIL beq_mp_count got=%0d want=%0d", mispredict_count, exp_mc); end
        total++; if (branch_count !== 32'(exp_bc)) begin bad++; $display("FAIL beq_br_count got=%0d want=%0d", branch_count, exp_bc); end
        total++; if (dut.bht[0] !== 2'b10) begin bad++; $display("FAIL beq_bht0 got=%b want=10", dut.bht[0]); end
        idle();
        pc_f = 32'h100;
        #1;
        total++; if (pred_taken_f !== 1'b1) begin bad++; $display("FAIL beq_pred_f got=%0b want=1", pred_taken_f); end
        total++; if (redirect !== 1'b0) begin bad++; $display("FAIL beq_redirect_clears got=%0b want=0", redirect); end
    endtask

    task automatic test_signed_unsigned;
        drive(BLT, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h280, 1'b0);
        tick();
        exp_bc++; exp_mc++;
        total++; if (redirect !== 1'b1 || br_taken !== 1'b1) begin bad++; $display("FAIL blt_taken redirect=%0b br_taken=%0b want 1/1", redirect, br_taken); end
        total++; if (redirect_pc !== 32'h280) begin bad++; $display("FAIL blt_redirect_pc got=%h want=00000280", redirect_pc); end
        idle();
        drive(BLTU, 32'hFFFF_FFFF, 32'h1, 32'h204, 32'h284, 1'b0);
        tick();
        exp_bc++;
        total++; if (redirect !== 1'b0 || br_taken !== 1'b0) begin bad++; $display("FAIL bltu_not_taken redirect=%0b br_taken=%0b want 0/0", redirect, br_taken); end
        total++; if (redirect_pc !== 32'h280) begin bad++; $display("FAIL bltu_pc_hold got=%h want=00000280", redirect_pc); end
        drive(BGEU, 32'hFFFF_FFFF, 32'h1, 32'h208, 32'h300, 1'b0);
        tick();
        exp_bc++; exp_mc++;
        total++; if (redirect !== 1'b1 || br_taken !== 1'b1) begin bad++; $display("FAIL bgeu_taken redirect=%0b br_taken=%0b want 1/1", redirect, br_taken); end
        total++; if (redirect_pc !== 32'h300) begin bad++; $display("FAIL bgeu_redirect_pc got=%h want=00000300", redirect_pc); end
        total++; if (branch_count !== 32'(exp_bc) || mispredict_count !== 32'(exp_mc)) begin
            bad++; $display("FAIL sign_counts bc=%0d mc=%0d want %0d/%0d", branch_count, mispredict_count, exp_bc, exp_mc);
        end
        total++; if (dut.bht[0] !== 2'b11 || dut.bht[1] !== 2'b00 || dut.bht[2] !== 2'b10) begin
            bad++; $display("FAIL sign_bht got=%b/%b/%b want 11/00/10", dut.bht[0], dut.bht[1], dut.bht[2]);
        end
        idle();
    endtask

    task automatic test_back_to_back;
        drive(BEQ, 32'h1, 32'h2, 32'h10C, 32'h900, 1'b1);
        tick();
        exp_bc++; exp_mc++;
        total++; if (redirect !== 1'b1 || redirect_pc !== 32'h110) begin
            bad++; $display("FAIL b2b_first redirect=%0b pc=%h want 1/00000110", redirect, redirect_pc);
        end
        drive(BNE, 32'h1, 32'h2, 32'h110, 32'h400, 1'b0);
        tick();
        total++; if (redirect !== 1'b0 || br_taken !== 1'b0) begin bad++; $display("FAIL b2b_squash redirect=%0b br_taken=%0b want 0/0", redirect, br_taken); end
        total++; if (branch_count !== 32'(exp_bc) || mispredict_count !== 32'(exp_mc)) begin
            bad++; $display("FAIL b2b_counts bc=%0d mc=%0d want %0d/%0d", branch_count, mispredict_count, exp_bc, exp_mc);
        end
        total++; if (redirect_pc !== 32'h110) begin bad++; $display("FAIL b2b_pc_hold got=%h want=00000110", redirect_pc); end
        total++; if (dut.bht[4] !== 2'b01 || dut.bht[3] !== 2'b00) begin
            bad++; $display("FAIL b2b_bht idx4=%b idx3=%b want 01/00", dut.bht[4], dut.bht[3]);
        end
        idle();
    endtask

    task automatic test_saturate;
        logic [1:0] exp_bht [8];
        exp_bht[0] = 2'b10; exp_bht[1] = 2'b11; exp_bht[2] = 2'b11; exp_bht[3] = 2'b11;
        exp_bht[4] = 2'b10; exp_bht[5] = 2'b01; exp_bht[6] = 2'b00; exp_bht[7] = 2'b00;
        pc_f = 32'h20;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) drive(BEQ, 32'h7, 32'h7, 32'h20, 32'h80, 1'b1);
            else       drive(BEQ, 32'h7, 32'h8, 32'h20, 32'h80, 1'b0);
            if (i == 0) begin
                #1;
                total++; if (pred_taken_f !== 1'b0) begin bad++; $display("FAIL collision_no_bypass got=%0b want=0", pred_taken_f); end
            end
            tick();
            exp_bc++;
            total++; if (dut.bht[8] !== exp_bht[i] || redirect !== 1'b0) begin
                bad++; $display("FAIL sat_step%0d bht=%b redirect=%0b want %b/0", i, dut.bht[8], redirect, exp_bht[i]);
            end
        end
        total++; if (pred_taken_f !== 1'b0) begin bad++; $display("FAIL sat_pred_f got=%0b want=0", pred_taken_f); end
        total++; if (branch_count !== 32'(exp_bc) || mispredict_count !== 32'(exp_mc)) begin
            bad++; $display("FAIL sat_counts bc=%0d mc=%0d want %0d/%0d", branch_count, mispredict_count, exp_bc, exp_mc);
        end
        idle();
    endtask

    task automatic test_wrap_nb_uc;
        drive(BEQ, 32'h1, 32'h2, 32'hFFFF_FFFC, 32'h1234, 1'b1);
        tick();
        exp_bc++; exp_mc++;
        total++; if (redirect !== 1'b1 || redirect_pc !== 32'h0) begin
            bad++; $display("FAIL wrap redirect=%0b pc=%h want 1/00000000", redirect, redirect_pc);
        end
        idle();
        drive(NB, 32'h1, 32'h1, 32'h50, 32'h60, 1'b1);
        tick();
        total++; if (redirect !== 1'b0 || br_taken !== 1'b0) begin bad++; $display("FAIL nb_pred1 redirect=%0b br_taken=%0b want 0/0", redirect, br_taken); end
        drive(4'd12, 32'h1, 32'h1, 32'h50, 32'h60, 1'b0);
        tick();
        total++; if (redirect !== 1'b0 || br_taken !== 1'b0) begin bad++; $display("FAIL reserved_op redirect=%0b br_taken=%0b want 0/0", redirect, br_taken); end
        drive(UC, 32'h0, 32'h0, 32'h38, 32'h7000, 1'b0);
        tick();
        exp_mc++;
        total++; if (redirect !== 1'b1 || redirect_pc !== 32'h7000 || br_taken !== 1'b1) begin
            bad++; $display("FAIL uc_pred0 redirect=%0b pc=%h br_taken=%0b want 1/00007000/1", redirect, redirect_pc, br_taken);
        end
        idle();
        drive(UC, 32'h0, 32'h0, 32'h38, 32'h7100, 1'b1);
        tick();
        total++; if (redirect !== 1'b0 || br_taken !== 1'b1) begin bad++; $display("FAIL uc_pred1 redirect=%0b br_taken=%0b want 0/1", redirect, br_taken); end
        total++; if (dut.bht[14] !== 2'b01) begin bad++; $display("FAIL uc_no_train got=%b want=01", dut.bht[14]); end
        total++; if (branch_count !== 32'(exp_bc) || mispredict_count !== 32'(exp_mc)) begin
            bad++; $display("FAIL wrap_counts bc=%0d mc=%0d want %0d/%0d", branch_count, mispredict_count, exp_bc, exp_mc);
        end
        idle();
    endtask

    task automatic test_reset_mid;
        drive(BEQ, 32'h3, 32'h3, 32'h140, 32'h500, 1'b0);
        tick();
        total++; if (redirect !== 1'b1) begin bad++; $display("FAIL midrst_pre redirect=%0b want=1", redirect); end
        rst = 1'b1;
        drive(BNE, 32'h3, 32'h4, 32'h144, 32'h600, 1'b0);
        tick();
        total++; if (redirect !== 1'b0 || br_taken !== 1'b0 || redirect_pc !== 32'h0) begin
            bad++; $display("FAIL midrst_outputs redirect=%0b br_taken=%0b pc=%h want 0/0/0", redirect, br_taken, redirect_pc);
        end
        total++; if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
            bad++; $display("FAIL midrst_counts bc=%0d mc=%0d want 0/0", branch_count, mispredict_count);
        end
        total++; if (dut.bht[0] !== 2'b01) begin bad++; $display("FAIL midrst_bht got=%b want=01", dut.bht[0]); end
        drive(BEQ, 32'h3, 32'h3, 32'h140, 32'h500, 1'b0);
        tick();
        total++; if (redirect !== 1'b0 || mispredict_count !== 32'd0) begin
            bad++; $display("FAIL rst_discards_mp redirect=%0b mc=%0d want 0/0", redirect, mispredict_count);
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        test_reset();
        test_beq();
        test_signed_unsigned();
        test_back_to_back();
        test_saturate();
        test_wrap_nb_uc();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor to the combinational branch comparator: resolves the full RV32 branch set at XLEN width, adds a direct-mapped 2-bit bimodal predictor (BHT), and registers the result into a one-cycle redirect/flush pulse.
- Fetch reads predictions; execute supplies resolved operands.
- Also maintains branch and mispredict performance counters.

Parameters:
- XLEN, 32, operand and PC width.
- BHT_ENTRIES, 16, predictor entries; power of two, 2..1024.
- IDX_W, $clog2(BHT_ENTRIES), BHT index width; derived, not overridden.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- pc_f  in  XLEN  fetch PC for prediction lookup.
- pred_taken_f  out  1  combinational prediction: bht[pc_f[IDX_W+1:2]][1].
- ex_valid  in  1  execute-stage instruction valid.
- br_op  in  4  operation: 0 NB, 1 BEQ, 2 BNE, 3 BLT, 4 UC, 5 BGE, 6 BLTU, 7 BGEU; 8..15 reserved.
- operand1, operand2  in  XLEN  compare operands.
- pc_x  in  XLEN  PC of the execute instruction.
- target_x  in  XLEN  computed branch/jump target.
- pred_taken_x  in  1  prediction carried from fetch with this instruction.
- br_taken  out  1  registered actual outcome.
- redirect  out  1  registered one-cycle mispredict pulse; flushes fetch/decode.
- redirect_pc  out  XLEN  registered correct next PC, valid while redirect=1.
- branch_count  out  CNT_W  resolved conditional branches.
- mispredict_count  out  CNT_W  redirects issued.

Behaviour:
- Reset (rst=1 at a clock edge):
  - br_taken=0, redirect=0, redirect_pc=0, both counters=0.
  - Every BHT entry = 2'b01 (weakly not-taken).
  - Reset mid-operation discards any pending redirect and squash in the same edge.
- Outcome logic (combinational, from ex inputs):
  - BEQ/BNE: equality.
  - BLT/BGE: signed compare.
  - BLTU/BGEU: unsigned compare.
  - UC: taken=1.
  - NB and reserved ops: taken=0.
- Effective valid: eff_v = ex_valid & ~redirect. The instruction in execute during a redirect cycle is wrong-path and is fully ignored: no BHT update, no counter update, no redirect.
- cond = eff_v & br_op in {1,2,3,5,6,7}.
- Mispredict:
  - Conditional branch: mp = cond & (taken != pred_taken_x).
  - UC: mp = eff_v & ~pred_taken_x.
  - NB and reserved ops never mispredict, regardless of pred_taken_x.
- Registered at each edge (latency 1):
  - br_taken <= eff_v & taken.
  - redirect <= mp.
  - redirect_pc <= taken ? target_x : pc_x + 4, modulo 2^XLEN wrap. It updates only when mp=1; otherwise it holds.
- Back-to-back mispredicts cannot produce redirect on two consecutive cycles, because of the squash rule.
- BHT update (only when cond=1), at index pc_x[IDX_W+1:2]:
  - taken: saturating increment (11 stays 11).
  - not taken: saturating decrement (00 stays 00).
  - UC does not train the BHT.
- Read/write collision: the BHT write lands at the clock edge. pred_taken_f in the same cycle returns the pre-update value; there is no bypass.
- Counters:
  - branch_count += cond.
  - mispredict_count += mp.
  - Both wrap modulo 2^CNT_W.
- PC bits [1:0] and bits above IDX_W+1 are ignored for indexing; aliasing is accepted.

Test Plan:
- Reset, then pc_f=0x40 -> pred_taken_f=0 for every index; all outputs 0.
- BEQ, op1=op2=0x5, pred=0, pc_x=0x100, target_x=0x180 -> next cycle br_taken=1, redirect=1, redirect_pc=0x180, mispredict_count=1, bht[0]=10. Then pc_f=0x100 -> pred_taken_f=1.
- BLT vs BLTU, op1=0xFFFFFFFF, op2=1, pred=0 -> BLT taken (redirect=1); BLTU not taken (redirect=0); BGEU taken.
- Mispredicted branch followed next cycle by a valid BNE with a would-be mispredict -> second instruction squashed: redirect=0, branch_count unchanged, BHT unchanged.
- Four taken BEQ at pc 0x20 -> bht saturates at 11. Then three not-taken -> 00, then stays 00 on a fourth not-taken.
- Not-taken branch at pc_x=0xFFFFFFFC with pred=1 -> redirect_pc=0x00000000 (wrap). NB with pred=1 -> redirect=0. Assert rst during the redirect cycle -> redirect=0 and counters=0 next cycle.
